lfsr_run_ctrl: RTL and testbench
================================

// Module: lfsr_run_ctrl
// PURPOSE
//  Sequencer for the 12-bit LFSR datapath. On a start command it seeds the
//  LFSR, enables it for a programmed step count (or until its max_tick),
//  captures the final value and reports done. Sits between the top-level
//  control logic and lfsr, on the same divided clk that drives lfsr.
// PARAMETERS
//  WIDTH   12  LFSR state width; widths of seed, lfsr_seed, lfsr_out, result
//  STEP_W  16  width of the step counter, num_steps and steps_done
// PORTS
//  clk         in   1       system clock; all logic on its rising edge
//  reset       in   1       synchronous, active-low reset
//  start       in   1       run request; sampled in IDLE only
//  seed        in   WIDTH   seed value; latched with start
//  num_steps   in   STEP_W  steps to run; 0 = free-run until max_tick
//  abort       in   1       terminate the current run early
//  lfsr_out    in   WIDTH   current LFSR state
//  max_tick    in   1       LFSR wrapped to its terminal state
//  lfsr_load   out  1       one-cycle seed load strobe to the LFSR
//  lfsr_seed   out  WIDTH   seed presented to the LFSR
//  lfsr_en     out  1       LFSR step enable
//  busy        out  1       high from LOAD through DONE
//  done        out  1       one-cycle completion pulse
//  aborted     out  1       valid with done: run ended by abort
//  result      out  WIDTH   lfsr_out captured at DONE; held until next done
//  steps_done  out  STEP_W  enabled cycles in the last run; held
//  seed_err    out  1       one-cycle pulse: start with seed == 0 rejected
//  period_err  out  1       see CONFIGURATION
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE. All outputs 0. Applies from any state.
//  FSM states: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  IDLE: start & seed!=0 -> latch seed and num_steps, go LOAD.
//        start & seed==0 -> seed_err for 1 cycle, stay IDLE, no load.
//  LOAD (1 cycle): lfsr_load=1, lfsr_seed=latched seed. Step counter := 0.
//  RUN: lfsr_en=1 every cycle. Counter += 1 per enabled cycle.
//   Exit to DONE when the cycle is the num_steps-th enabled cycle (N>0),
//   or max_tick==1 with N==0, or abort==1.
//   Terminal condition and abort in the same cycle: aborted=0.
//   N>0: max_tick is ignored. N==0: counter wraps modulo 2**STEP_W.
//  DONE (1 cycle): lfsr_en=0, done=1. result<=lfsr_out, steps_done<=counter.
//   aborted=1 only if abort ended the run.
//  Latency: start at cycle 0 -> lfsr_load at 1 -> lfsr_en at 2..N+1 -> done at N+2.
//  abort in LOAD: go to DONE, steps_done=0, aborted=1.
//  start outside IDLE is ignored. It is not queued.
//  lfsr_seed holds its latched value after LOAD.
// CONFIGURATION
//  LFSR_PERIOD_CHK_EN defined:
//   In RUN, count enabled cycles between consecutive max_tick pulses.
//   On the 2nd and later max_tick, interval != 2**WIDTH-1 -> period_err=1.
//   period_err is sticky. It is cleared by reset or an accepted start.
//  Not defined: period_err tied 0. No counter logic is built.
// TESTING
//  1 reset=0 for 2 clks, random inputs -> every output 0, no lfsr_load/en.
//  2 seed=12'h001, num_steps=5, start for 1 clk -> lfsr_load at cycle 1;
//    lfsr_en at cycles 2-6; done at cycle 7; steps_done=5;
//    result = reference model after 5 steps.
//  3 seed=0, start -> seed_err 1 cycle, busy=0, lfsr_load never asserted.
//  4 num_steps=0, seed=12'h001 -> stop on max_tick; done next cycle;
//    steps_done = model distance to terminal state; aborted=0.
//  5 num_steps=100, abort on 3rd RUN cycle -> done next cycle, aborted=1,
//    steps_done=3. Start pulse while busy -> ignored.
//  6 reset=0 mid-RUN -> all outputs 0 next edge; start afterwards runs cleanly.
//    With LFSR_PERIOD_CHK_EN and a model LFSR forced to a short period,
//    period_err=1.

Source files
------------

// File: rtl/lfsr_run_ctrl_if.sv
// Command/status interface between the top-level control logic (master)
// and the LFSR run sequencer (slave).
interface lfsr_run_ctrl_if #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 16
);
  logic              start;
  logic [WIDTH-1:0]  seed;
  logic [STEP_W-1:0] num_steps;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [WIDTH-1:0]  result;
  logic [STEP_W-1:0] steps_done;
  logic              seed_err;
  logic              period_err;

  modport master (
    output start, seed, num_steps, abort,
    input  busy, done, aborted, result, steps_done, seed_err, period_err
  );

  modport slave (
    input  start, seed, num_steps, abort,
    output busy, done, aborted, result, steps_done, seed_err, period_err
  );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: seeds the LFSR, enables it for num_steps cycles (or until
// max_tick when num_steps==0), then captures the final state and pulses done.
// Optional feature macro: LFSR_PERIOD_CHK_EN (max_tick interval checker
// driving period_err; when undefined period_err is tied low).
// result/steps_done are captured during the DONE cycle, so they become
// visible on the cycle after the done pulse.
module lfsr_run_ctrl #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_run_ctrl_if.slave    bus,
  input  logic [WIDTH-1:0]  lfsr_out,
  input  logic              max_tick,
  output logic              lfsr_load,
  output logic [WIDTH-1:0]  lfsr_seed,
  output logic              lfsr_en
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  logic [STEP_W-1:0] n_q;
  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] cnt_inc;
  logic              term;
  logic              busy_q, done_q, aborted_q, seed_err_q;
  logic [WIDTH-1:0]  result_q;
  logic [STEP_W-1:0] steps_done_q;

  // Terminal condition of the current RUN cycle (max_tick only in free-run).
  assign cnt_inc = cnt + STEP_W'(1);
  assign term    = (n_q != '0) ? (cnt_inc == n_q) : max_tick;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      n_q          <= '0;
      cnt          <= '0;
      lfsr_load    <= 1'b0;
      lfsr_seed    <= '0;
      lfsr_en      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      seed_err_q   <= 1'b0;
      result_q     <= '0;
      steps_done_q <= '0;
    end else begin
      lfsr_load  <= 1'b0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.seed != '0) begin
              lfsr_seed <= bus.seed;
              n_q       <= bus.num_steps;
              cnt       <= '0;
              lfsr_load <= 1'b1;
              busy_q    <= 1'b1;
              state     <= LOAD;
            end else begin
              seed_err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            state     <= DONE;
          end else begin
            lfsr_en <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt_inc;
          if (term || bus.abort) begin
            lfsr_en   <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= bus.abort & ~term;
            state     <= DONE;
          end
        end
        DONE: begin
          result_q     <= lfsr_out;
          steps_done_q <= cnt;
          busy_q       <= 1'b0;
          aborted_q    <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.seed_err   = seed_err_q;
  assign bus.result     = result_q;
  assign bus.steps_done = steps_done_q;

`ifdef LFSR_PERIOD_CHK_EN
  localparam logic [WIDTH-1:0] FULL_PERIOD = {WIDTH{1'b1}};

  logic             accept;
  logic [WIDTH-1:0] pcnt;
  logic             tick_seen;
  logic             period_err_q;

  assign accept = (state == IDLE) && bus.start && (bus.seed != '0);

  // Measure enabled cycles between max_tick pulses; flag a short/long period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt         <= '0;
      tick_seen    <= 1'b0;
      period_err_q <= 1'b0;
    end else if (accept) begin
      pcnt         <= '0;
      tick_seen    <= 1'b0;
      period_err_q <= 1'b0;
    end else if (state == RUN) begin
      if (max_tick) begin
        if (tick_seen && ((pcnt + WIDTH'(1)) != FULL_PERIOD))
          period_err_q <= 1'b1;
        tick_seen <= 1'b1;
        pcnt      <= '0;
      end else begin
        pcnt <= pcnt + WIDTH'(1);
      end
    end
  end

  assign bus.period_err = period_err_q;
`else
  assign bus.period_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Self-checking bench for lfsr_run_ctrl: a behavioural 12-bit LFSR drives
// lfsr_out/max_tick, and expected results come from stepping a reference
// LFSR function the required number of times.
module tb_lfsr_run_ctrl;
  localparam int WIDTH  = 12;
  localparam int STEP_W = 16;
`ifdef LFSR_PERIOD_CHK_EN
  localparam bit PERR_SHORT = 1'b1;
`else
  localparam bit PERR_SHORT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WIDTH-1:0]  lfsr_out;
  logic              max_tick;
  logic              lfsr_load;
  logic [WIDTH-1:0]  lfsr_seed;
  logic              lfsr_en;

  lfsr_run_ctrl_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  lfsr_run_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .lfsr_out  (lfsr_out),
    .max_tick  (max_tick),
    .lfsr_load (lfsr_load),
    .lfsr_seed (lfsr_seed),
    .lfsr_en   (lfsr_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference LFSR: Fibonacci, taps 12,6,4,1.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], q[11] ^ q[5] ^ q[3] ^ q[0]};
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s, input int k);
    logic [WIDTH-1:0] q;
    q = s;
    for (int i = 0; i < k; i++) q = lfsr_step(q);
    return q;
  endfunction

  logic [WIDTH-1:0] term_st;
  bit               short_mode = 1'b0;
  logic [WIDTH-1:0] q = 12'h001;

  function automatic int dist_to_term(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] x;
    x = s;
    for (int d = 0; d < 4096; d++) begin
      if (x == term_st) return d;
      x = lfsr_step(x);
    end
    return 5000;
  endfunction

  // Environment LFSR; short_mode replaces it with a period-7 sequence.
  always @(posedge clk) begin
    if (lfsr_load) q <= lfsr_seed;
    else if (lfsr_en) q <= short_mode ? ((q == 12'd7) ? 12'd1 : q + 12'd1) : lfsr_step(q);
  end
  assign lfsr_out = q;
  assign max_tick = short_mode ? (q == 12'd7) : (q == term_st);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {17'd0, lfsr_load, lfsr_seed, lfsr_en, bus.busy, bus.done, bus.aborted,
            bus.result, bus.steps_done, bus.seed_err, bus.period_err};
  endfunction

  // One run: ab_at = -1 none, 0 abort in LOAD, k>0 abort on k-th RUN cycle.
  task automatic run(input logic [WIDTH-1:0] s, input logic [STEP_W-1:0] n,
                     input int ab_at, input bit noisy, input bit chk_res, input bit exp_perr);
    int c, en_cnt, loads, nat, exp_steps;
    bit exp_ab, got;
    logic [WIDTH-1:0] exp_res;
    nat = (n != 0) ? int'(n) : dist_to_term(s) + 1;
    if (ab_at == 0) begin
      exp_steps = 0; exp_ab = 1'b1;
    end else if (ab_at > 0 && ab_at < nat) begin
      exp_steps = ab_at; exp_ab = 1'b1;
    end else begin
      exp_steps = nat; exp_ab = 1'b0;
    end
    exp_res = adv(s, exp_steps);

    bus.seed = s; bus.num_steps = n; bus.start = 1'b1;
    tick;
    bus.start = 1'b0; bus.seed = WIDTH'($urandom); bus.num_steps = STEP_W'($urandom);
    chk("load_strobe", lfsr_load, 1);
    chk("load_seed", lfsr_seed, s);
    chk("load_busy", bus.busy, 1);
    loads = 0; en_cnt = 0; got = 1'b0;
    for (c = 1; c < 6000; c++) begin
      if (bus.done) begin got = 1'b1; break; end
      if (lfsr_load && c > 1) loads++;
      if (lfsr_en) en_cnt++;
      bus.abort = (c == 1 && ab_at == 0) || (lfsr_en && ab_at > 0 && en_cnt == ab_at);
      bus.start = noisy && ($urandom_range(0, 3) == 0);
      tick;
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("done_seen", got, 1);
    chk("done_cycle", c, exp_steps + 2);
    chk("aborted", bus.aborted, exp_ab);
    chk("en_cycles", en_cnt, exp_steps);
    chk("busy_at_done", bus.busy, 1);
    chk("extra_load", loads, 0);
    tick;
    chk("done_pulse", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("steps_done", bus.steps_done, exp_steps);
    if (chk_res) chk("result", bus.result, exp_res);
    chk("period_err", bus.period_err, exp_perr);
  endtask

  initial begin
    int n, ab, r;
    logic [WIDTH-1:0] s;
    term_st = adv(12'h001, 1000);
    bus.start = 1'b0; bus.seed = '0; bus.num_steps = '0; bus.abort = 1'b0;

    // 1: reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'(($urandom)); bus.seed = WIDTH'($urandom | 1);
      bus.num_steps = STEP_W'($urandom); bus.abort = 1'($urandom);
      tick;
      chk("reset_outs", outs(), 0);
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    reset = 1'b1;
    tick;
    chk("post_reset_outs", outs(), 0);

    // 2: directed 5-step run
    run(12'h001, 16'd5, -1, 1'b0, 1'b1, 1'b0);

    // 3: zero seed rejected
    bus.seed = '0; bus.num_steps = 16'd4; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("seed_err_pulse", bus.seed_err, 1);
    chk("seed_err_busy", bus.busy, 0);
    chk("seed_err_load", lfsr_load, 0);
    tick;
    chk("seed_err_clear", bus.seed_err, 0);
    chk("seed_err_noload", lfsr_load, 0);

    // 4: free-run to max_tick
    run(12'h001, 16'd0, -1, 1'b0, 1'b1, 1'b0);

    // 5: abort on 3rd RUN cycle with start noise, then abort in LOAD
    run(WIDTH'($urandom_range(1, 4095)), 16'd100, 3, 1'b1, 1'b1, 1'b0);
    run(WIDTH'($urandom_range(1, 4095)), 16'd20, 0, 1'b0, 1'b1, 1'b0);
    // abort coinciding with terminal count is not an abort
    run(WIDTH'($urandom_range(1, 4095)), 16'd6, 6, 1'b0, 1'b1, 1'b0);

    // randomized runs
    for (int k = 0; k < 14; k++) begin
      n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
      s = (n == 0) ? adv(12'h001, $urandom_range(0, 3000)) : WIDTH'($urandom_range(1, 4095));
      r = $urandom_range(0, 3);
      ab = (r == 0) ? -1 : (r == 1) ? 0 : $urandom_range(1, (n == 0) ? 60 : n + 2);
      run(s, STEP_W'(n), ab, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    // period checker: short-period LFSR sequence
    short_mode = 1'b1;
    run(12'h001, 16'd30, -1, 1'b0, 1'b0, PERR_SHORT);
    short_mode = 1'b0;
    run(12'h00F, 16'd3, -1, 1'b0, 1'b1, 1'b0);

    // 6: reset mid-RUN, then a clean run
    bus.seed = 12'h005; bus.num_steps = 16'd50; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    chk("mid_run_en", lfsr_en, 1);
    reset = 1'b0;
    tick;
    chk("mid_run_reset_outs", outs(), 0);
    reset = 1'b1;
    tick;
    chk("after_reset_outs", outs(), 0);
    run(12'hA5A, 16'd9, -1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
